// File: rtl/conv_operand_loader.sv
// Operand loader for the 4x4-image / 3x3-kernel serial convolution filter.
// Collects a 25-byte frame, starts the filter, and holds operands until it finishes.
module conv_operand_loader #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] a11, a12, a13, a14,
  output logic [DW-1:0] a21, a22, a23, a24,
  output logic [DW-1:0] a31, a32, a33, a34,
  output logic [DW-1:0] a41, a42, a43, a44,
  output logic [DW-1:0] b11, b12, b13,
  output logic [DW-1:0] b21, b22, b23,
  output logic [DW-1:0] b31, b32, b33,
  output logic          filter_rst,
  input  logic          filter_done,
  output logic          busy,
  output logic          frame_err,
  output logic          timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {LOAD, START, BUSY} state_t;

  state_t        state, state_n;
  logic [4:0]    cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          done_q;
  logic          accept, rel, frame_bad, tmo;
  logic [DW-1:0] img  [16];
  logic [DW-1:0] kern [9];

  assign in_ready   = (state == LOAD);
  assign filter_rst = (state == START);
  assign busy       = (state != LOAD);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  // Only a 0->1 edge of filter_done releases BUSY, so a done left high is ignored.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tcnt_n    = tcnt;
    accept    = 1'b0;
    rel       = 1'b0;
    frame_bad = 1'b0;
    tmo       = 1'b0;
    case (state)
      LOAD: begin
        accept = in_valid;
        if (accept) begin
          if (cnt < 5'd24) begin
            if (in_last) begin
              frame_bad = 1'b1;
              cnt_n     = 5'd0;
            end else begin
              cnt_n = cnt + 5'd1;
            end
          end else begin
            cnt_n = 5'd0;
            if (in_last) state_n   = START;
            else         frame_bad = 1'b1;
          end
        end
      end
      START: begin
        state_n = BUSY;
        tcnt_n  = '0;
      end
      BUSY: begin
        rel = filter_done & ~done_q;
        if (rel) begin
          state_n = LOAD;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_n = LOAD;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Bytes 0..15 land in the image bank, 16..24 in the kernel bank via cnt[3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 5'd0;
      tcnt        <= '0;
      done_q      <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 16; i++) img[i]  <= '0;
      for (int i = 0; i < 9; i++)  kern[i] <= '0;
    end else begin
      cnt         <= cnt_n;
      tcnt        <= tcnt_n;
      done_q      <= filter_done;
      frame_err   <= frame_bad;
      timeout_err <= tmo;
      if (accept) begin
        if (!cnt[4])                       img[cnt[3:0]]  <= in_data;
        else if (cnt < 5'd24 || in_last)   kern[cnt[3:0]] <= in_data;
      end
    end
  end

  assign a11 = img[0];  assign a12 = img[1];  assign a13 = img[2];  assign a14 = img[3];
  assign a21 = img[4];  assign a22 = img[5];  assign a23 = img[6];  assign a24 = img[7];
  assign a31 = img[8];  assign a32 = img[9];  assign a33 = img[10]; assign a34 = img[11];
  assign a41 = img[12]; assign a42 = img[13]; assign a43 = img[14]; assign a44 = img[15];

  assign b11 = kern[0]; assign b12 = kern[1]; assign b13 = kern[2];
  assign b21 = kern[3]; assign b22 = kern[4]; assign b23 = kern[5];
  assign b31 = kern[6]; assign b32 = kern[7]; assign b33 = kern[8];

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader: frames, malformed frames, stale done,
// filter timeout and mid-frame / mid-BUSY reset.
module tb_conv_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic       filter_rst, filter_done, busy, frame_err, timeout_err;

  logic [7:0] img_o  [16];
  logic [7:0] kern_o [9];

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  conv_operand_loader #(.DW(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14), .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34), .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13), .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .filter_rst(filter_rst), .filter_done(filter_done), .busy(busy),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always_comb begin
    img_o[0]  = a11; img_o[1]  = a12; img_o[2]  = a13; img_o[3]  = a14;
    img_o[4]  = a21; img_o[5]  = a22; img_o[6]  = a23; img_o[7]  = a24;
    img_o[8]  = a31; img_o[9]  = a32; img_o[10] = a33; img_o[11] = a34;
    img_o[12] = a41; img_o[13] = a42; img_o[14] = a43; img_o[15] = a44;
    kern_o[0] = b11; kern_o[1] = b12; kern_o[2] = b13;
    kern_o[3] = b21; kern_o[4] = b22; kern_o[5] = b23;
    kern_o[6] = b31; kern_o[7] = b32; kern_o[8] = b33;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One byte presented for exactly one clock edge.
  task automatic apply_stimulus(input logic [7:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input int last_at,
                            input bit bubbly);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(8'(base + i), (i == last_at));
      if (bubbly && i != n - 1) tick();
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] base);
    for (int i = 0; i < 16; i++)
      check_output($sformatf("%s_a%0d", tag, i), 32'(img_o[i]), 32'(8'(base + i)));
    for (int j = 0; j < 9; j++)
      check_output($sformatf("%s_b%0d", tag, j), 32'(kern_o[j]), 32'(8'(base + 16 + j)));
  endtask

  task automatic release_filter(input string tag);
    filter_done = 1'b1;
    tick();
    check_output({tag, "_rel_busy"},  32'(busy), 32'd0);
    check_output({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    filter_done = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; filter_done = 1'b0;
    tick();
    tick();
    $display("[TB] reset state");
    check_output("rst_ready", 32'(in_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_frst", 32'(filter_rst), 32'd0);
    check_output("rst_ferr", 32'(frame_err), 32'd0);
    check_output("rst_terr", 32'(timeout_err), 32'd0);
    check_output("rst_a11", 32'(a11), 32'd0);
    check_output("rst_b33", 32'(b33), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] nominal frame 1..25");
    send_frame(8'd1, 25, 24, 1'b0);
    check_output("nom_frst", 32'(filter_rst), 32'd1);
    check_output("nom_busy", 32'(busy), 32'd1);
    check_output("nom_ready", 32'(in_ready), 32'd0);
    check_frame("nom", 8'd1);
    tick();
    check_output("nom_frst_pulse", 32'(filter_rst), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check_output("nom_wait_ready", 32'(in_ready), 32'd0);
    check_output("nom_wait_busy", 32'(busy), 32'd1);
    release_filter("nom");
    check_output("nom_hold_a44", 32'(a44), 32'd16);

    $display("[TB] early in_last on byte 10");
    send_frame(8'h50, 10, 9, 1'b0);
    check_output("early_ferr", 32'(frame_err), 32'd1);
    check_output("early_frst", 32'(filter_rst), 32'd0);
    check_output("early_ready", 32'(in_ready), 32'd1);
    tick();
    check_output("early_ferr_pulse", 32'(frame_err), 32'd0);
    send_frame(8'hA0, 25, 24, 1'b0);
    check_output("clean_frst", 32'(filter_rst), 32'd1);
    check_frame("clean", 8'hA0);
    tick();
    release_filter("clean");

    $display("[TB] bubbly frame 1..25");
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(8'(1 + i), 1'b0);
      tick();
    end
    check_output("bub_gap_frst", 32'(filter_rst), 32'd0);
    check_output("bub_gap_ready", 32'(in_ready), 32'd1);
    apply_stimulus(8'd25, 1'b1);
    check_output("bub_frst", 32'(filter_rst), 32'd1);
    check_frame("bub", 8'd1);
    tick();
    release_filter("bub");

    $display("[TB] missing in_last on byte 25");
    send_frame(8'h60, 25, -1, 1'b0);
    check_output("miss_ferr", 32'(frame_err), 32'd1);
    check_output("miss_frst", 32'(filter_rst), 32'd0);
    check_output("miss_busy", 32'(busy), 32'd0);
    check_output("miss_ready", 32'(in_ready), 32'd1);
    check_output("miss_b32", 32'(b32), 32'h77);
    check_output("miss_b33_kept", 32'(b33), 32'd25);
    send_frame(8'h70, 25, 24, 1'b0);
    check_output("after_miss_frst", 32'(filter_rst), 32'd1);
    check_frame("after_miss", 8'h70);

    $display("[TB] stale done held through START");
    filter_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_output("stale_busy", 32'(busy), 32'd1);
    check_output("stale_ready", 32'(in_ready), 32'd0);
    filter_done = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_output("stale_low_busy", 32'(busy), 32'd1);
    release_filter("stale");

    $display("[TB] filter timeout");
    send_frame(8'h30, 25, 24, 1'b0);
    check_output("tmo_frst", 32'(filter_rst), 32'd1);
    for (int i = 0; i < 64; i++) tick();
    check_output("tmo_c64_busy", 32'(busy), 32'd1);
    check_output("tmo_c64_terr", 32'(timeout_err), 32'd0);
    tick();
    check_output("tmo_terr", 32'(timeout_err), 32'd1);
    check_output("tmo_ferr", 32'(frame_err), 32'd0);
    check_output("tmo_busy", 32'(busy), 32'd0);
    check_output("tmo_ready", 32'(in_ready), 32'd1);
    tick();
    check_output("tmo_terr_pulse", 32'(timeout_err), 32'd0);

    $display("[TB] reset at byte 7");
    send_frame(8'hC0, 6, -1, 1'b0);
    in_valid = 1'b1; in_data = 8'hC6; rst = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b0;
    check_output("mrst_a11", 32'(a11), 32'd0);
    check_output("mrst_a23", 32'(a23), 32'd0);
    check_output("mrst_b33", 32'(b33), 32'd0);
    check_output("mrst_busy", 32'(busy), 32'd0);
    check_output("mrst_ready", 32'(in_ready), 32'd1);
    send_frame(8'hD0, 25, 24, 1'b0);
    check_output("post_rst_frst", 32'(filter_rst), 32'd1);
    check_frame("post_rst", 8'hD0);

    $display("[TB] reset during BUSY");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("brst_busy", 32'(busy), 32'd0);
    check_output("brst_frst", 32'(filter_rst), 32'd0);
    check_output("brst_ready", 32'(in_ready), 32'd1);
    check_output("brst_a11", 32'(a11), 32'd0);
    check_output("brst_terr", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
